// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch-redirect controller with post-redirect shadow window.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module pc_fetch_ctrl #(
  parameter int unsigned         PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_valid,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                redirect,
  output logic                shadow
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         branch_count,
  output logic [31:0]         taken_count
`endif
);

  localparam int unsigned    CntW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(FLUSH_CYCLES - 1);

  typedef enum logic {StRun, StShadow} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q;
  logic                take;
  logic                unused_target_lsb;

  // Targets are forced halfword-aligned, so the LSB of the input is never used.
  assign unused_target_lsb = branch_target[0];

  assign take     = (state_q == StRun) && branch_valid && branch_taken;
  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (take) begin
      // A taken branch beats stall: the stalled instruction is on the wrong path.
      state_d = StShadow;
      cnt_d   = CntLoad;
      pc_d    = {branch_target[PC_WIDTH-1:1], 1'b0};
    end else begin
      if (!stall) begin
        pc_d = pc_plus4;
      end
      if (state_q == StShadow) begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flush_q <= take;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_flush = flush_q;
  assign id_ex_flush = flush_q;
  assign redirect    = flush_q;
  assign shadow      = (state_q == StShadow);

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] taken_cnt_q;

  // Saturating counters; branches squashed in the shadow window are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      if ((state_q == StRun) && branch_valid && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (take && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;
`endif

endmodule
